// File: rtl/computie_bus_capture.sv
// Triggered capture engine for the Computie bus: synchronises the strobes, records each completed
// transaction into a circular buffer with pre-trigger history, then drains it oldest-first.
module computie_bus_capture #(
    parameter int BITWIDTH    = 32,
    parameter int DEPTH       = 32,
    parameter int PRE_TRIGGER = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                        comm_clock,
    input  logic                        comm_reset,
    input  logic                        cb_addr_strobe,
    input  logic                        cb_data_strobe,
    input  logic                        cb_read_write,
    input  logic [BITWIDTH-1:0]         cb_addr_data_bus,
    output logic                        addr_oe,
    output logic                        data_oe,
    input  logic                        record_start,
    input  logic                        record_abort,
    input  logic                        record_trigger,
    input  logic [BITWIDTH-1:0]         trig_addr,
    input  logic [BITWIDTH-1:0]         trig_mask,
    input  logic                        trig_rw_en,
    input  logic                        trig_rw,
    output logic                        triggered,
    output logic                        record_end,
    output logic                        record_out_valid,
    input  logic                        record_out_ready,
    output logic [2*BITWIDTH+1:0]       record_out,
    output logic [$clog2(DEPTH):0]      record_out_count
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int REC_W = 2*BITWIDTH + 2;

    typedef enum logic [1:0] {WAIT_AS, WAIT_DS, WAIT_END} bus_state_t;
    typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} cap_state_t;

    bus_state_t bus_state, bus_next;
    cap_state_t cap_state, cap_next;

    logic [SYNC_STAGES-1:0] as_sync, ds_sync, rw_sync;
    logic                   as_prev, ds_prev;
    logic                   as_s, ds_s, rw_s;
    logic                   as_fall, as_rise, ds_fall, ds_rise;

    logic [BITWIDTH-1:0]    bus_addr, bus_data;
    logic                   bus_rw, complete, tx_armed;
    logic [PTR_W-1:0]       wr_ptr, rd_ptr;
    logic [CNT_W-1:0]       count;
    logic [REC_W-1:0]       mem [DEPTH];
    logic                   capturing, wr_en, match_trig, trig_now, accept;

    // Strobes idle high, so the synchronisers reset high to avoid a false edge after reset.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
            as_sync <= '1;
            ds_sync <= '1;
            rw_sync <= '0;
            as_prev <= 1'b1;
            ds_prev <= 1'b1;
        end else begin
            as_sync[0] <= cb_addr_strobe;
            ds_sync[0] <= cb_data_strobe;
            rw_sync[0] <= cb_read_write;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                as_sync[i] <= as_sync[i-1];
                ds_sync[i] <= ds_sync[i-1];
                rw_sync[i] <= rw_sync[i-1];
            end
            as_prev <= as_s;
            ds_prev <= ds_s;
        end
    end

    assign as_s    = as_sync[SYNC_STAGES-1];
    assign ds_s    = ds_sync[SYNC_STAGES-1];
    assign rw_s    = rw_sync[SYNC_STAGES-1];
    assign as_fall = as_prev & ~as_s;
    assign as_rise = ~as_prev & as_s;
    assign ds_fall = ds_prev & ~ds_s;
    assign ds_rise = ~ds_prev & ds_s;

    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) bus_state <= WAIT_AS;
        else            bus_state <= bus_next;
    end

    always_comb begin
        // NOTE: default first so no path leaves bus_next unassigned and infers a latch.
        bus_next = bus_state;
        case (bus_state)
            WAIT_AS:  if (as_fall) bus_next = WAIT_DS;
            WAIT_DS:  if (ds_fall) bus_next = WAIT_END;
                      else if (as_rise) bus_next = WAIT_AS;
            WAIT_END: if (ds_rise) bus_next = WAIT_AS;
            default:  bus_next = WAIT_AS;
        endcase
    end

    always_comb begin
        addr_oe = (bus_state != WAIT_DS);
        data_oe = (bus_state != WAIT_END);
    end

    // tx_armed remembers whether the address phase began while a capture was running.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            bus_addr <= '0;
            bus_data <= '0;
            bus_rw   <= 1'b0;
            complete <= 1'b0;
            tx_armed <= 1'b0;
        end else begin
            complete <= (bus_state == WAIT_END) && ds_rise;
            if (bus_state == WAIT_AS && as_fall) begin
                bus_addr <= cb_addr_data_bus;
                tx_armed <= capturing;
            end else if (cap_state == IDLE) begin
                tx_armed <= 1'b0;
            end
            if (bus_state == WAIT_END && ds_rise) begin
                bus_data <= cb_addr_data_bus;
                bus_rw   <= rw_s;
            end
        end
    end

    assign capturing  = (cap_state == ARMED) || (cap_state == POST);
    assign wr_en      = complete && tx_armed && capturing;
    assign match_trig = wr_en && (cap_state == ARMED)
                        && (((bus_addr ^ trig_addr) & trig_mask) == '0)
                        && (!trig_rw_en || (bus_rw == trig_rw));
    assign trig_now   = (cap_state == ARMED) && (match_trig || record_trigger);
    assign accept     = record_out_valid && record_out_ready;

    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) cap_state <= IDLE;
        else            cap_state <= cap_next;
    end

    always_comb begin
        cap_next = cap_state;
        case (cap_state)
            IDLE:  if (record_start && !record_abort) cap_next = ARMED;
            ARMED: if (record_abort) cap_next = IDLE;
                   else if (trig_now)
                       cap_next = (wr_en && count == CNT_W'(DEPTH-1)) ? DONE : POST;
            POST:  if (record_abort) cap_next = IDLE;
                   else if (wr_en && count == CNT_W'(DEPTH-1)) cap_next = DONE;
            DONE:  if (record_abort) cap_next = IDLE;
                   else if (accept && count == CNT_W'(1)) cap_next = IDLE;
            default: cap_next = IDLE;
        endcase
    end

    always_comb begin
        triggered        = (cap_state == POST) || (cap_state == DONE);
        record_end       = (cap_state == DONE);
        record_out_valid = (cap_state == DONE) && (count != '0);
        record_out       = record_out_valid ? mem[rd_ptr] : '0;
        record_out_count = count;
    end

    // Pointers sit at zero while idle, so arming always starts from a clean buffer.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (cap_state == IDLE || record_abort) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (wr_en) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
            if (cap_state == ARMED && !trig_now && count == CNT_W'(PRE_TRIGGER))
                rd_ptr <= rd_ptr + PTR_W'(1);
            else
                count <= count + CNT_W'(1);
        end else if (accept) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
            count  <= count - CNT_W'(1);
        end
    end

    // NOTE: the record store has no reset; count and record_out_valid gate every read of it.
    always_ff @(posedge comm_clock) begin
        if (wr_en) mem[wr_ptr] <= {bus_rw, match_trig, bus_addr, bus_data};
    end

endmodule

// File: tb/tb_computie_bus_capture.sv
// Randomised bench for computie_bus_capture against a queue-based capture model.
module tb_computie_bus_capture;
    localparam int BW    = 32;
    localparam int DEPTH = 8;
    localparam int PRE   = 3;
    localparam int SYNC  = 2;
    localparam int REC_W = 2*BW + 2;
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             comm_clock = 1'b0;
    logic             comm_reset;
    logic             cb_addr_strobe, cb_data_strobe, cb_read_write;
    logic [BW-1:0]    cb_addr_data_bus;
    logic             addr_oe, data_oe;
    logic             record_start, record_abort, record_trigger;
    logic [BW-1:0]    trig_addr, trig_mask;
    logic             trig_rw_en, trig_rw;
    logic             triggered, record_end, record_out_valid, record_out_ready;
    logic [REC_W-1:0] record_out;
    logic [CNT_W-1:0] record_out_count;

    computie_bus_capture #(
        .BITWIDTH(BW), .DEPTH(DEPTH), .PRE_TRIGGER(PRE), .SYNC_STAGES(SYNC)
    ) dut (
        .comm_clock(comm_clock), .comm_reset(comm_reset),
        .cb_addr_strobe(cb_addr_strobe), .cb_data_strobe(cb_data_strobe),
        .cb_read_write(cb_read_write), .cb_addr_data_bus(cb_addr_data_bus),
        .addr_oe(addr_oe), .data_oe(data_oe),
        .record_start(record_start), .record_abort(record_abort),
        .record_trigger(record_trigger), .trig_addr(trig_addr), .trig_mask(trig_mask),
        .trig_rw_en(trig_rw_en), .trig_rw(trig_rw), .triggered(triggered),
        .record_end(record_end), .record_out_valid(record_out_valid),
        .record_out_ready(record_out_ready), .record_out(record_out),
        .record_out_count(record_out_count)
    );

    always #5 comm_clock = ~comm_clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: the capture is a queue of records plus three phase flags.
    logic [REC_W-1:0] mq[$];
    bit m_armed, m_trig, m_done;

    function automatic bit is_match(input logic [BW-1:0] a, input logic rw);
        return (((a ^ trig_addr) & trig_mask) == '0) && (!trig_rw_en || rw == trig_rw);
    endfunction

    task automatic model_tx(input logic [BW-1:0] a, input logic [BW-1:0] d, input logic rw);
        bit hit;
        if (m_armed && !m_done) begin
            if (!m_trig) begin
                hit = is_match(a, rw);
                mq.push_back({rw, hit, a, d});
                if (hit) m_trig = 1;
                else if (mq.size() > PRE) void'(mq.pop_front());
            end else begin
                mq.push_back({rw, 1'b0, a, d});
            end
            if (mq.size() == DEPTH) m_done = 1;
        end
    endtask

    task automatic model_clear();
        mq.delete();
        m_armed = 0;
        m_trig  = 0;
        m_done  = 0;
    endtask

    task automatic check_state(input string tag);
        check({tag, "_count"}, record_out_count, mq.size());
        check({tag, "_triggered"}, triggered, m_trig);
        check({tag, "_record_end"}, record_end, m_done);
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge comm_clock);
    endtask

    task automatic bus_cycle(input logic [BW-1:0] a, input logic [BW-1:0] d,
                             input logic rw, input bit chk_oe);
        @(negedge comm_clock);
        cb_read_write    = rw;
        cb_addr_data_bus = a;
        wait_cycles(1);
        cb_addr_strobe = 1'b0;
        wait_cycles(4);
        if (chk_oe) begin
            check("oe_addr_phase_addr_oe", addr_oe, 1'b0);
            check("oe_addr_phase_data_oe", data_oe, 1'b1);
        end
        cb_addr_data_bus = d;
        wait_cycles(1);
        cb_data_strobe = 1'b0;
        wait_cycles(4);
        if (chk_oe) begin
            check("oe_data_phase_addr_oe", addr_oe, 1'b1);
            check("oe_data_phase_data_oe", data_oe, 1'b0);
        end
        cb_data_strobe = 1'b1;
        cb_addr_strobe = 1'b1;
        wait_cycles(4);
        if (chk_oe) begin
            check("oe_end_addr_oe", addr_oe, 1'b1);
            check("oe_end_data_oe", data_oe, 1'b1);
        end
        wait_cycles(2);
    endtask

    task automatic tx(input logic [BW-1:0] a, input logic [BW-1:0] d, input logic rw);
        bus_cycle(a, d, rw, 1'b0);
        model_tx(a, d, rw);
        check_state("tx");
    endtask

    task automatic as_only();
        @(negedge comm_clock);
        cb_addr_data_bus = 32'h0BAD;
        cb_addr_strobe   = 1'b0;
        wait_cycles(4);
        check("as_only_addr_oe_low", addr_oe, 1'b0);
        cb_addr_strobe = 1'b1;
        wait_cycles(4);
        check("as_only_addr_oe_high", addr_oe, 1'b1);
        check("as_only_data_oe_high", data_oe, 1'b1);
    endtask

    task automatic do_start();
        @(negedge comm_clock);
        record_start = 1'b1;
        @(negedge comm_clock);
        record_start = 1'b0;
        if (!m_armed) begin
            mq.delete();
            m_armed = 1;
        end
    endtask

    task automatic do_abort();
        @(negedge comm_clock);
        record_abort = 1'b1;
        @(negedge comm_clock);
        record_abort = 1'b0;
        model_clear();
    endtask

    task automatic do_trigger();
        @(negedge comm_clock);
        record_trigger = 1'b1;
        @(negedge comm_clock);
        record_trigger = 1'b0;
        if (m_armed && !m_trig) m_trig = 1;
        check_state("manual_trigger");
    endtask

    // mode 0: always ready, 1: 1-1-0 toggling with a 5-cycle gap, 2: random ready.
    task automatic drain(input int mode);
        int i;
        bit r;
        i = 0;
        while (mq.size() > 0 && i < 400) begin
            @(negedge comm_clock);
            case (mode)
                0:       r = 1'b1;
                1:       r = (i >= 4 && i < 9) ? 1'b0 : ((i % 3) != 2);
                default: r = 1'($urandom_range(0, 1));
            endcase
            check("drain_valid", record_out_valid, 1'b1);
            check("drain_record", record_out, mq[0]);
            check("drain_count", record_out_count, mq.size());
            record_out_ready = r;
            if (r) void'(mq.pop_front());
            i++;
        end
        check("drain_left_over", mq.size(), 0);
        @(negedge comm_clock);
        record_out_ready = 1'b0;
        model_clear();
        check("post_drain_valid", record_out_valid, 1'b0);
        check_state("post_drain");
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_addr_oe"}, addr_oe, 1'b1);
        check({tag, "_data_oe"}, data_oe, 1'b1);
        check({tag, "_valid"}, record_out_valid, 1'b0);
        check({tag, "_record_out"}, record_out, '0);
        check({tag, "_count"}, record_out_count, 0);
        check({tag, "_triggered"}, triggered, 1'b0);
        check({tag, "_record_end"}, record_end, 1'b0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [BW-1:0] a;
        comm_reset       = 1'b1;
        cb_addr_strobe   = 1'b1;
        cb_data_strobe   = 1'b1;
        cb_read_write    = 1'b0;
        cb_addr_data_bus = '0;
        record_start     = 1'b0;
        record_abort     = 1'b0;
        record_trigger   = 1'b0;
        record_out_ready = 1'b0;
        trig_addr        = '0;
        trig_mask        = '0;
        trig_rw_en       = 1'b0;
        trig_rw          = 1'b0;
        model_clear();
        wait_cycles(3);
        check_reset_outputs("reset");
        comm_reset = 1'b0;
        wait_cycles(2);

        // Unarmed bus cycle: transceiver enables sequence but nothing is stored.
        bus_cycle(32'h100, 32'hAA, 1'b0, 1'b1);
        check("unarmed_count", record_out_count, 0);
        check("unarmed_valid", record_out_valid, 1'b0);

        // Pre-trigger saturation, address-match trigger, full drain.
        trig_addr  = 32'h200;
        trig_mask  = 32'hFFFF_FFFF;
        trig_rw_en = 1'b0;
        do_start();
        for (int i = 0; i < 5; i++) tx(32'h10 + i, $urandom, 1'($urandom_range(0, 1)));
        tx(32'h200, $urandom, 1'b0);
        for (int i = 1; i < 5; i++) tx(32'h200 + i, $urandom, 1'($urandom_range(0, 1)));
        drain(0);

        // Read/write-only trigger with an ignored-address mask; throttled drain.
        trig_rw_en = 1'b1;
        trig_rw    = 1'b1;
        trig_mask  = '0;
        do_start();
        tx(32'h300, $urandom, 1'b0);
        tx(32'h304, $urandom, 1'b1);
        for (int k = 0; k < 20 && !m_done; k++) tx($urandom, $urandom, 1'($urandom_range(0, 1)));
        drain(1);

        // Random triggers on low address bits, with a manual trigger fallback.
        for (int r = 0; r < 3; r++) begin
            trig_addr  = $urandom_range(0, 15);
            trig_mask  = 32'hF;
            trig_rw_en = 1'($urandom_range(0, 1));
            trig_rw    = 1'($urandom_range(0, 1));
            do_start();
            for (int k = 0; k < 30 && !m_done; k++) begin
                if (k == 6 && !m_trig) do_trigger();
                tx($urandom_range(0, 63), $urandom, 1'($urandom_range(0, 1)));
            end
            check("random_capture_done", record_end, 1'b1);
            drain(2);
        end

        // Aborted address-only cycle, ignored re-start, then abort during POST.
        trig_addr  = 32'h200;
        trig_mask  = 32'hFFFF_FFFF;
        trig_rw_en = 1'b0;
        do_start();
        tx(32'h40, $urandom, 1'b0);
        as_only();
        check_state("after_as_only");
        do_start();
        check_state("restart_ignored");
        tx(32'h200, $urandom, 1'b1);
        tx(32'h41, $urandom, 1'b0);
        do_abort();
        check_state("after_abort");
        check("after_abort_valid", record_out_valid, 1'b0);

        // Asynchronous reset in the middle of a drain.
        do_start();
        do_trigger();
        for (int k = 0; k < 20 && !m_done; k++) begin
            a = $urandom;
            tx(a, $urandom, 1'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge comm_clock);
            check("partial_drain_record", record_out, mq[0]);
            record_out_ready = 1'b1;
            void'(mq.pop_front());
        end
        @(negedge comm_clock);
        record_out_ready = 1'b0;
        #2 comm_reset = 1'b1;
        #1 check_reset_outputs("mid_drain_reset");
        model_clear();
        wait_cycles(2);
        comm_reset = 1'b0;
        wait_cycles(2);
        check_reset_outputs("after_reset_release");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/computie_bus_capture.md
Name: computie_bus_capture

Overview:
- Triggered logic-analyser capture engine for the Computie bus, successor to the free-running bus snooper.
- Oversamples asynchronous bus strobes on comm_clock and records each completed transaction into an internal circular buffer with pre-trigger history.
- Triggers on a masked address match and/or read/write match, or on a manual trigger.
- After capture it drains the records, oldest first, over a valid/ready interface to the comm side.

Parameters:
BITWIDTH, 32, width of the multiplexed address/data bus
DEPTH, 32, total records held per capture (power of two, >= 4)
PRE_TRIGGER, 8, maximum records retained before the trigger (1 <= PRE_TRIGGER < DEPTH)
SYNC_STAGES, 2, synchroniser flops on cb_addr_strobe, cb_data_strobe and cb_read_write

Ports:
comm_clock  in  1  sole clock
comm_reset  in  1  asynchronous active-high reset
cb_addr_strobe  in  1  bus address strobe, active low, asynchronous
cb_data_strobe  in  1  bus data strobe, active low, asynchronous
cb_read_write  in  1  bus direction, asynchronous
cb_addr_data_bus  in  BITWIDTH  multiplexed address/data
addr_oe  out  1  address transceiver enable, active low
data_oe  out  1  data transceiver enable, active low
record_start  in  1  one-cycle pulse that arms a capture
record_abort  in  1  one-cycle pulse that abandons the capture
record_trigger  in  1  one-cycle pulse that forces the trigger
trig_addr  in  BITWIDTH  trigger address
trig_mask  in  BITWIDTH  1 = compare this bit
trig_rw_en  in  1  include read/write in the match
trig_rw  in  1  required cb_read_write value when trig_rw_en = 1
triggered  out  1  trigger has occurred in this capture
record_end  out  1  buffer full, drain in progress
record_out_valid  out  1  record_out holds a valid record
record_out_ready  in  1  consumer accepts the record
record_out  out  2*BITWIDTH+2  {rw, trig_flag, address, data}
record_out_count  out  $clog2(DEPTH)+1  records currently stored

Behaviour:
- Reset (asynchronous): capture FSM = IDLE, bus FSM = WAIT_AS, pointers and count = 0. addr_oe = data_oe = 1. All other outputs = 0. Reset asserted mid-capture discards everything immediately.
- Synchronisation: strobes and rw pass through SYNC_STAGES flops. Edges are detected on the synchronised values. cb_addr_data_bus is sampled raw at the detected edge; the bus is stable by then.
- Bus FSM runs in every capture state:
  - WAIT_AS: on the AS falling edge, latch the address, set addr_oe = 0, go to WAIT_DS.
  - WAIT_DS: on the DS falling edge, set addr_oe = 1 and data_oe = 0, go to WAIT_END. If AS rises first, the cycle is aborted: return to WAIT_AS with no record.
  - WAIT_END: on the DS rising edge, latch data and rw, set data_oe = 1, pulse "complete" for 1 cycle, go to WAIT_AS.
  - A DS edge seen in WAIT_AS is ignored.
- Record write: 1 cycle after "complete", i.e. SYNC_STAGES+2 comm_clock cycles after the DS pin rises. Writes happen only in ARMED or POST. trig_flag = 1 only on the record that caused an address/rw match trigger.
- Match: ((address ^ trig_addr) & trig_mask) == 0, AND (!trig_rw_en OR rw == trig_rw). Evaluated on "complete".
- Capture FSM:
  - IDLE: record_start moves to ARMED with pointers cleared. Only transactions whose AS edge occurs after arming are recorded.
  - ARMED: each record is written at the write pointer and count increments. Once count reaches PRE_TRIGGER, each new write also advances the read pointer, so count stays at PRE_TRIGGER and the oldest record is dropped. A match, or record_trigger, sets triggered = 1 and moves to POST. The matching record is stored and counts as a post-trigger record.
  - POST: keep writing until count == DEPTH, then go to DONE with record_end = 1. Further transactions are ignored.
  - DONE: record_out_valid = 1 while count > 0. record_out = entry at the read pointer. On valid & ready, advance the read pointer (mod DEPTH) and decrement count. When the last record is accepted: go to IDLE, record_end = 0, triggered = 0.
- record_out_valid and record_out stay stable until accepted.
- Priority and boundaries:
  - record_abort beats record_start.
  - record_abort in any non-IDLE state returns to IDLE and clears pointers, count, triggered and record_end.
  - record_start outside IDLE is ignored.
  - record_trigger outside ARMED is ignored.
  - Match and record_trigger in the same cycle: a single trigger, with trig_flag set on the matching record.
  - Pointers wrap mod DEPTH.

Test Plan (DEPTH=8, PRE_TRIGGER=3, SYNC_STAGES=2):
- Reset, then one bus write A=0x100, D=0xAA with no record_start -> no record; addr_oe then data_oe pulse low in order; record_out_count = 0.
- Arm; 5 transactions A=0x10..0x14; trig_addr=0x200, mask=0xFFFFFFFF -> count saturates at 3, holding 0x12..0x14, triggered = 0.
- Continue with A=0x200 then 0x201..0x204 -> triggered = 1 on 0x200 and record_end = 1 after 0x204. Drain with ready = 1 -> 8 records 0x12,0x13,0x14,0x200(trig_flag=1),0x201..0x204; then valid = 0 and FSM back in IDLE.
- trig_rw_en = 1, trig_rw = 1, mask = 0: a write, then a read -> trigger on the read only; trig_flag = 1 on that record.
- Drain with ready toggling 1-0-1 and a 5-cycle ready gap -> no lost or duplicated records; record_out is held stable while ready = 0.
- AS asserted then released without DS; record_abort mid-POST; comm_reset mid-drain -> no record for the aborted cycle; abort returns count = 0 and triggered = 0; reset returns outputs to reset values immediately.
